// File: rtl/nibble_packer_if.sv
// Nibble packer bus: nibble source side and packed-word consumer side.
interface nibble_packer_if;
  logic [3:0]  nib_in;
  logic        nib_valid;
  logic        addr_mode;
  logic [1:0]  nib_addr;
  logic        clear;
  logic        word_ack;
  logic        nib_ready;
  logic [15:0] word_out;
  logic        word_valid;
  logic [1:0]  slot;
  logic [3:0]  slot_mask;

  // Driver of nibbles/acks (testbench or upstream logic)
  modport master (
    output nib_in, nib_valid, addr_mode, nib_addr, clear, word_ack,
    input  nib_ready, word_out, word_valid, slot, slot_mask
  );

  // The packer itself
  modport slave (
    input  nib_in, nib_valid, addr_mode, nib_addr, clear, word_ack,
    output nib_ready, word_out, word_valid, slot, slot_mask
  );
endinterface

// File: rtl/nibble_packer.sv
// Packs four 4-bit nibbles into a 16-bit word, either in auto-slot order or
// by explicit slot address. A completed word is held until acknowledged.
module nibble_packer #(
  parameter bit ACK_CLEARS_WORD = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  nibble_packer_if.slave  bus
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_word;
  logic [1:0]  r_slot;
  logic [3:0]  r_mask;
  logic        w_accept;
  logic [1:0]  w_target;
  logic [3:0]  w_mask_set;

  // Accept qualification, target slot selection and the mask after a write
  always_comb begin
    w_accept   = bus.nib_valid & (r_state == FILL);
    w_target   = bus.addr_mode ? bus.nib_addr : r_slot;
    w_mask_set = r_mask | (4'b0001 << w_target);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_state_nxt;
  end

  // Next state: clear dominates; the last distinct slot enters HOLD; ack leaves it
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = FILL;
    end else begin
      unique case (r_state)
        FILL: if (w_accept && (w_mask_set == 4'b1111)) w_state_nxt = HOLD;
        HOLD: if (bus.word_ack) w_state_nxt = FILL;
        default: w_state_nxt = FILL;
      endcase
    end
  end

  // Word, slot pointer and fill mask; a nibble arriving with an ack in HOLD is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= '0;
      r_slot <= '0;
      r_mask <= '0;
    end else if (bus.clear) begin
      r_word <= '0;
      r_slot <= '0;
      r_mask <= '0;
    end else if ((r_state == HOLD) && bus.word_ack) begin
      r_slot <= '0;
      r_mask <= '0;
      if (ACK_CLEARS_WORD) r_word <= '0;
    end else if (w_accept) begin
      r_word[{w_target, 2'b00} +: 4] <= bus.nib_in;
      r_mask <= w_mask_set;
      if (!bus.addr_mode) r_slot <= r_slot + 2'd1;
    end
  end

  assign bus.nib_ready  = (r_state == FILL);
  assign bus.word_valid = (r_state == HOLD);
  assign bus.word_out   = r_word;
  assign bus.slot       = r_slot;
  assign bus.slot_mask  = r_mask;

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: two instances (ACK_CLEARS_WORD=0/1)
// share the same stimulus; completed words are predicted by a small model.
module tb_nibble_packer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nibble_packer_if ifc0 ();
  nibble_packer_if ifc1 ();

  nibble_packer #(.ACK_CLEARS_WORD(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(ifc0.slave));
  nibble_packer #(.ACK_CLEARS_WORD(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(ifc1.slave));

  assign ifc1.nib_in    = ifc0.nib_in;
  assign ifc1.nib_valid = ifc0.nib_valid;
  assign ifc1.addr_mode = ifc0.addr_mode;
  assign ifc1.nib_addr  = ifc0.nib_addr;
  assign ifc1.clear     = ifc0.clear;
  assign ifc1.word_ack  = ifc0.word_ack;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  // reference model
  logic [15:0] m_word, m_word1;
  logic [3:0]  m_mask;
  logic [1:0]  m_slot;
  logic        m_hold;

  task automatic model_zero();
    m_word = '0; m_word1 = '0; m_mask = '0; m_slot = '0; m_hold = 1'b0;
  endtask

  task automatic model_ack();
    m_word1 = '0; m_mask = '0; m_slot = '0; m_hold = 1'b0;
  endtask

  // present one nibble for one cycle and update the model
  task automatic send(input logic mode, input logic [1:0] addr, input logic [3:0] data);
    logic [1:0] tgt;
    ifc0.nib_valid = 1'b1;
    ifc0.addr_mode = mode;
    ifc0.nib_addr  = addr;
    ifc0.nib_in    = data;
    if (!m_hold) begin
      tgt = mode ? addr : m_slot;
      m_word[int'(tgt)*4 +: 4]  = data;
      m_word1[int'(tgt)*4 +: 4] = data;
      m_mask[tgt] = 1'b1;
      if (!mode) m_slot = m_slot + 2'd1;
      if (m_mask == 4'hF) begin
        m_hold = 1'b1;
        exp_q.push_back(m_word);
      end
    end
    @(posedge clk); #1;
    ifc0.nib_valid = 1'b0;
  endtask

  task automatic test_reset();
    ifc0.nib_in = '0; ifc0.nib_valid = 0; ifc0.addr_mode = 0;
    ifc0.nib_addr = '0; ifc0.clear = 0; ifc0.word_ack = 0;
    reset = 1'b1;
    model_zero();
    #12;
    checks++; if (ifc0.nib_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ifc0.nib_ready); end
    checks++; if (ifc0.word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifc0.word_valid); end
    checks++; if (ifc0.word_out !== 16'h0000) begin failures++; $display("FAIL reset_word got=%h exp=0000", ifc0.word_out); end
    checks++; if (ifc0.slot !== 2'b00) begin failures++; $display("FAIL reset_slot got=%b exp=00", ifc0.slot); end
    checks++; if (ifc0.slot_mask !== 4'b0000) begin failures++; $display("FAIL reset_mask got=%b exp=0000", ifc0.slot_mask); end
    checks++; if (ifc1.word_out !== 16'h0000) begin failures++; $display("FAIL reset_word1 got=%h exp=0000", ifc1.word_out); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_auto_fill();
    send(1'b0, 2'b00, 4'h4);
    checks++; if (ifc0.slot_mask !== 4'b0001) begin failures++; $display("FAIL auto_mask1 got=%b exp=0001", ifc0.slot_mask); end
    checks++; if (ifc0.slot !== 2'b01) begin failures++; $display("FAIL auto_slot1 got=%b exp=01", ifc0.slot); end
    checks++; if (ifc0.word_valid !== 1'b0) begin failures++; $display("FAIL auto_valid1 got=%b exp=0", ifc0.word_valid); end
    send(1'b0, 2'b00, 4'h3);
    send(1'b0, 2'b00, 4'h2);
    send(1'b0, 2'b00, 4'h1);
    checks++; if (ifc0.word_valid !== 1'b1) begin failures++; $display("FAIL auto_valid got=%b exp=1", ifc0.word_valid); end
    checks++; if (ifc0.nib_ready !== 1'b0) begin failures++; $display("FAIL auto_ready got=%b exp=0", ifc0.nib_ready); end
    checks++; if (ifc0.slot !== 2'b00) begin failures++; $display("FAIL auto_slot got=%b exp=00", ifc0.slot); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL auto_sb_empty got=%h exp=<none>", ifc0.word_out); end
    else begin
      exp_w = exp_q.pop_front();
      if (ifc0.word_out !== exp_w) begin failures++; $display("FAIL auto_word got=%h exp=%h", ifc0.word_out, exp_w); end
      checks++; if (ifc1.word_out !== exp_w) begin failures++; $display("FAIL auto_word1 got=%h exp=%h", ifc1.word_out, exp_w); end
    end
  endtask

  task automatic test_backpressure();
    ifc0.nib_valid = 1'b1; ifc0.nib_in = 4'hF; ifc0.addr_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (ifc0.word_out !== m_word) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, ifc0.word_out, m_word); end
      checks++; if (ifc0.word_valid !== 1'b1) begin failures++; $display("FAIL bp_valid%0d got=%b exp=1", i, ifc0.word_valid); end
    end
    // ack with the nibble still presented: nibble must be dropped
    ifc0.word_ack = 1'b1;
    @(posedge clk); #1;
    ifc0.word_ack = 1'b0; ifc0.nib_valid = 1'b0;
    model_ack();
    checks++; if (ifc0.nib_ready !== 1'b1) begin failures++; $display("FAIL ack_ready got=%b exp=1", ifc0.nib_ready); end
    checks++; if (ifc0.word_valid !== 1'b0) begin failures++; $display("FAIL ack_valid got=%b exp=0", ifc0.word_valid); end
    checks++; if (ifc0.slot_mask !== m_mask) begin failures++; $display("FAIL ack_mask got=%b exp=%b", ifc0.slot_mask, m_mask); end
    checks++; if (ifc0.slot !== m_slot) begin failures++; $display("FAIL ack_slot got=%b exp=%b", ifc0.slot, m_slot); end
    checks++; if (ifc0.word_out !== m_word) begin failures++; $display("FAIL ack_word got=%h exp=%h", ifc0.word_out, m_word); end
    checks++; if (ifc1.word_out !== m_word1) begin failures++; $display("FAIL ack_word_cleared got=%h exp=%h", ifc1.word_out, m_word1); end
  endtask

  task automatic test_ack_in_fill();
    send(1'b0, 2'b00, 4'h7);
    ifc0.word_ack = 1'b1;
    @(posedge clk); #1;
    ifc0.word_ack = 1'b0;
    checks++; if (ifc0.slot_mask !== m_mask) begin failures++; $display("FAIL fillack_mask got=%b exp=%b", ifc0.slot_mask, m_mask); end
    checks++; if (ifc0.slot !== m_slot) begin failures++; $display("FAIL fillack_slot got=%b exp=%b", ifc0.slot, m_slot); end
    checks++; if (ifc0.word_out !== m_word) begin failures++; $display("FAIL fillack_word got=%h exp=%h", ifc0.word_out, m_word); end
    checks++; if (ifc1.word_out !== m_word1) begin failures++; $display("FAIL fillack_word1 got=%h exp=%h", ifc1.word_out, m_word1); end
  endtask

  task automatic test_clear();
    ifc0.clear = 1'b1;
    @(posedge clk); #1;
    ifc0.clear = 1'b0;
    model_zero();
    checks++; if (ifc0.word_out !== 16'h0000) begin failures++; $display("FAIL clr0_word got=%h exp=0000", ifc0.word_out); end
    send(1'b0, 2'b00, 4'h5);
    send(1'b0, 2'b00, 4'h6);
    checks++; if (ifc0.slot !== 2'b10) begin failures++; $display("FAIL clr_pre_slot got=%b exp=10", ifc0.slot); end
    checks++; if (ifc0.slot_mask !== 4'b0011) begin failures++; $display("FAIL clr_pre_mask got=%b exp=0011", ifc0.slot_mask); end
    checks++; if (ifc0.word_out !== m_word) begin failures++; $display("FAIL clr_pre_word got=%h exp=%h", ifc0.word_out, m_word); end
    // clear together with a valid nibble
    ifc0.clear = 1'b1; ifc0.nib_valid = 1'b1; ifc0.nib_in = 4'h9; ifc0.addr_mode = 1'b0;
    @(posedge clk); #1;
    ifc0.clear = 1'b0; ifc0.nib_valid = 1'b0;
    model_zero();
    checks++; if (ifc0.word_out !== 16'h0000) begin failures++; $display("FAIL clr_word got=%h exp=0000", ifc0.word_out); end
    checks++; if (ifc0.slot !== 2'b00) begin failures++; $display("FAIL clr_slot got=%b exp=00", ifc0.slot); end
    checks++; if (ifc0.slot_mask !== 4'b0000) begin failures++; $display("FAIL clr_mask got=%b exp=0000", ifc0.slot_mask); end
  endtask

  task automatic test_addressed();
    send(1'b1, 2'b11, 4'hA);
    send(1'b1, 2'b00, 4'hB);
    send(1'b1, 2'b11, 4'hC);
    checks++; if (ifc0.slot_mask !== 4'b1001) begin failures++; $display("FAIL addr_mask got=%b exp=1001", ifc0.slot_mask); end
    checks++; if (ifc0.slot !== 2'b00) begin failures++; $display("FAIL addr_slot got=%b exp=00", ifc0.slot); end
    send(1'b1, 2'b01, 4'hD);
    checks++; if (ifc0.word_valid !== 1'b0) begin failures++; $display("FAIL addr_valid4 got=%b exp=0", ifc0.word_valid); end
    send(1'b1, 2'b10, 4'hE);
    checks++; if (ifc0.word_valid !== 1'b1) begin failures++; $display("FAIL addr_valid got=%b exp=1", ifc0.word_valid); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL addr_sb_empty got=%h exp=<none>", ifc0.word_out); end
    else begin
      exp_w = exp_q.pop_front();
      if (ifc0.word_out !== exp_w) begin failures++; $display("FAIL addr_word got=%h exp=%h", ifc0.word_out, exp_w); end
      checks++; if (ifc1.word_out !== exp_w) begin failures++; $display("FAIL addr_word1 got=%h exp=%h", ifc1.word_out, exp_w); end
    end
    ifc0.word_ack = 1'b1;
    @(posedge clk); #1;
    ifc0.word_ack = 1'b0;
    model_ack();
    checks++; if (ifc0.word_out !== m_word) begin failures++; $display("FAIL addr_ack_word got=%h exp=%h", ifc0.word_out, m_word); end
    checks++; if (ifc1.word_out !== m_word1) begin failures++; $display("FAIL addr_ack_word1 got=%h exp=%h", ifc1.word_out, m_word1); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 4; i++) send(1'b0, 2'b00, 4'(i));
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL ar_sb_empty got=%h exp=<none>", ifc0.word_out); end
    else begin
      exp_w = exp_q.pop_front();
      if (ifc0.word_out !== exp_w) begin failures++; $display("FAIL ar_word_pre got=%h exp=%h", ifc0.word_out, exp_w); end
    end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++; if (ifc0.word_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", ifc0.word_valid); end
    checks++; if (ifc0.word_out !== 16'h0000) begin failures++; $display("FAIL ar_word got=%h exp=0000", ifc0.word_out); end
    checks++; if (ifc0.nib_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", ifc0.nib_ready); end
    checks++; if (ifc0.slot_mask !== 4'b0000) begin failures++; $display("FAIL ar_mask got=%b exp=0000", ifc0.slot_mask); end
    @(negedge clk); reset = 1'b0;
    model_zero();
    send(1'b0, 2'b00, 4'h9);
    checks++; if (ifc0.word_out !== m_word) begin failures++; $display("FAIL ar_post_word got=%h exp=%h", ifc0.word_out, m_word); end
    checks++; if (ifc0.slot_mask !== m_mask) begin failures++; $display("FAIL ar_post_mask got=%b exp=%b", ifc0.slot_mask, m_mask); end
    checks++; if (ifc0.slot !== m_slot) begin failures++; $display("FAIL ar_post_slot got=%b exp=%b", ifc0.slot, m_slot); end
  endtask

  initial begin
    test_reset();
    test_auto_fill();
    test_backpressure();
    test_ack_in_fill();
    test_clear();
    test_addressed();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 The block SHALL have parameter ACK_CLEARS_WORD, default 0, meaning: when 1, word_out is zeroed on the word_ack handshake.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock (rising edge).
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port nib_in, input, 4 bits, the nibble to be written.
REQ-005 The block SHALL have port nib_valid, input, 1 bit, which qualifies nib_in.
REQ-006 The block SHALL have port addr_mode, input, 1 bit: 0 selects auto-slot, 1 selects addressed write.
REQ-007 The block SHALL have port nib_addr, input, 2 bits, the target slot when addr_mode=1.
REQ-008 The block SHALL have port clear, input, 1 bit, a synchronous flush.
REQ-009 The block SHALL have port word_ack, input, 1 bit, the consumer acknowledge of word_valid.
REQ-010 The block SHALL have port nib_ready, output, 1 bit: a nibble is accepted on this cycle if nib_valid is high.
REQ-011 The block SHALL have port word_out, output, 16 bits, the assembled word.
REQ-012 The block SHALL have port word_valid, output, 1 bit: word_out is complete.
REQ-013 The block SHALL have port slot, output, 2 bits, the current auto-slot pointer.
REQ-014 The block SHALL have port slot_mask, output, 4 bits, one filled flag per slot.

Function
REQ-015 Slot mapping SHALL be: slot 00 = word_out[3:0], 01 = [7:4], 10 = [11:8], 11 = [15:12].
REQ-016 The FSM SHALL have two states: FILL (nib_ready=1, word_valid=0) and HOLD (nib_ready=0, word_valid=1); outputs are registered or decoded from state only.
REQ-017 Accept SHALL be nib_valid & nib_ready; the target slot is nib_addr if addr_mode=1, else slot.
REQ-018 On accept, the target nibble of word_out SHALL load nib_in and slot_mask[target] SHALL set on the next rising edge (1-cycle latency); other nibbles hold.
REQ-019 On an accept with addr_mode=0, slot SHALL increment modulo 4 (11 -> 00 wrap); with addr_mode=1, slot SHALL be unchanged.
REQ-020 An addressed write to an already-filled slot SHALL overwrite that nibble; slot_mask is unchanged for that slot.
REQ-021 When an accept makes slot_mask 4'b1111, the FSM SHALL enter HOLD on the same edge, so word_valid rises the cycle after the fourth distinct slot is written.
REQ-022 In HOLD, nib_valid SHALL be ignored and word_out SHALL be stable.
REQ-023 In HOLD with word_ack=1, the next edge SHALL produce: FILL, slot_mask=0000, slot=00; word_out is retained if ACK_CLEARS_WORD=0, else 0x0000.
REQ-024 word_ack in FILL SHALL have no effect.
REQ-025 clear=1 SHALL take priority over accept and ack: next state FILL, slot=00, slot_mask=0000, word_out=0x0000.
REQ-026 In HOLD, simultaneous word_ack and nib_valid SHALL return the block to FILL, and the nibble SHALL NOT be written; the source must re-present it.

Reset
REQ-027 While reset=1, independent of clk: state=FILL, word_out=0x0000, word_valid=0, nib_ready=1, slot=00, slot_mask=0000.
REQ-028 Reset asserted mid-word or in HOLD SHALL discard partial and complete words; the first accept after release SHALL target slot 00 in auto mode.

Verification
REQ-029 Auto fill: reset, then addr_mode=0 with nibbles 4,3,2,1 on consecutive cycles -> word_out=0x1234, word_valid=1 on the cycle after the 4th, nib_ready=0, slot=00.
REQ-030 Backpressure and ack: in HOLD, drive nib_valid=1 with 0xF for 3 cycles, then word_ack -> word_out stays 0x1234 and the next cycle shows FILL with slot_mask=0000.
REQ-031 Addressed fill: write 11:A, 00:B, 11:C, 01:D, 10:E -> the overwrite leaves slot_mask=1001 after the 3rd write, and after the 5th word_out=0xCEDB with word_valid=1.
REQ-032 Clear: after 2 auto nibbles (slot=10, mask=0011), pulse clear together with nib_valid -> word_out=0x0000, slot=00, mask=0000, nibble not written.
REQ-033 Async reset: assert reset between clock edges in HOLD -> word_valid=0 and word_out=0x0000 immediately, without waiting for a clk edge.
REQ-034 Parameter: with ACK_CLEARS_WORD=1, repeat the auto fill and ack -> word_out=0x0000 the cycle after ack.
